ram8: RTL and testbench
=======================

RAM8 -- requirements
Module: RAM8

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter CLEAR_VALUE, default 16'h0000, value written by the clear sequencer.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port in  input  WIDTH  write data.
REQ-007 SHALL have port load  input  1  write enable for word at address.
REQ-008 SHALL have port address  input  3  word select for both read and write.
REQ-009 SHALL have port clear  input  1  single-cycle request to start the clear sequence.
REQ-010 SHALL have port out  output  WIDTH  read data, word at address.
REQ-011 SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-012 SHALL hold 8 words of WIDTH bits, mem[0..7].
REQ-013 SHALL drive out = mem[address] combinationally, with zero-cycle read latency.
REQ-014 SHALL write in to mem[address] at the rising edge when load=1, busy=0, clear=0.
REQ-015 SHALL make a write visible on out from the cycle after the edge; it is not visible in the write cycle itself (see REQ-027).
REQ-016 SHALL implement FSM states IDLE and CLEARING with a 3-bit counter cnt.
REQ-017 SHALL, in IDLE with clear=1, transition to CLEARING with cnt=0 and busy=1 from the next cycle.
REQ-018 SHALL, in CLEARING, write CLEAR_VALUE to mem[cnt] each edge and increment cnt.
REQ-019 SHALL, in CLEARING with cnt=7, write mem[7], then return to IDLE with busy=0 next cycle; busy is high for exactly 8 cycles.
REQ-020 SHALL give clear priority over load when both are 1 in IDLE; that load is dropped.
REQ-021 SHALL ignore load and clear while busy=1, with no write, no restart and no queuing.
REQ-022 SHALL keep out tracking mem[address] during CLEARING, showing words as they are cleared.
REQ-023 SHALL NOT let cnt wrap past 7 back into CLEARING.

Reset
REQ-024 SHALL, on reset=1 at an edge, set all mem words to 0, FSM to IDLE, cnt to 0 and busy to 0.
REQ-025 SHALL make reset dominate load and clear in the same cycle.
REQ-026 SHALL, on reset during CLEARING, abort the sequence; no resumption after reset.

Configuration
REQ-027 SHALL, with RAM8_BYPASS_EN defined, drive out = in combinationally whenever load=1, busy=0, clear=0 and reset=0 (write-through forwarding).
REQ-028 SHALL, without RAM8_BYPASS_EN, drive out = stored mem[address] in every cycle, so a write shows the old value until the edge.

Structure
REQ-029 SHALL place WIDTH default, DEPTH=8, ADDR_W=3 and the IDLE/CLEARING state encoding in shared package ram8_pkg.
REQ-030 SHALL build the read path by instantiating the existing Mux8Way16 with sel=address.
REQ-031 SHALL implement storage and the FSM inside RAM8 with no other sub-modules.

Verification
REQ-032 SHALL cover: reset; write 246 @0, 2 @1 ... 8 @7; sweep address 0..7 with load=0 -> out = 246,2,3,4,5,6,7,8.
REQ-033 SHALL cover: load=1, address=3, in=100 -> without macro out=4 in the write cycle and 100 in the next; with macro out=100 in both.
REQ-034 SHALL cover: pulse clear with memory full of nonzero data -> busy high exactly 8 cycles; afterwards all words read 0; mid-sequence address=7 reads 8 until the 8th edge.
REQ-035 SHALL cover: load=1, address=2, in=55 at busy cycle 3 -> mem[2] stays 0 after clear completes; a second clear pulse while busy -> busy still drops after 8 cycles total.
REQ-036 SHALL cover: clear and load (address=5, in=9) in the same IDLE cycle -> mem[5]=0 after the sequence; reset asserted at busy cycle 4 -> busy=0 next cycle and all words 0.

Source files
------------

// File: rtl/ram8_pkg.sv
// Shared sizing and state encoding for the RAM8 word store and its clear sequencer.
package ram8_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH         = 8;
    localparam int ADDR_W        = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

endpackage

// File: rtl/ram8_mux8way16.sv
// Eight-way word multiplexer used as the RAM8 read path.
module Mux8Way16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/ram8.sv
// Eight-word RAM with a self-timed clear sequencer that rewrites every word over eight cycles.
// Define RAM8_BYPASS_EN to forward write data straight to out during an accepted write.
import ram8_pkg::*;

module ram8 #(
    parameter int               WIDTH       = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] cnt;
    state_t            state;
    logic [WIDTH-1:0]  mux_out;

    // Clear wins over load in IDLE; while clearing, both requests are simply ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEARING;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else if (load) begin
                        mem[address] <= in;
                    end
                end
                CLEARING: begin
                    mem[cnt] <= CLEAR_VALUE;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    Mux8Way16 #(
        .WIDTH(WIDTH)
    ) u_read_mux (
        .a  (mem[0]),
        .b  (mem[1]),
        .c  (mem[2]),
        .d  (mem[3]),
        .e  (mem[4]),
        .f  (mem[5]),
        .g  (mem[6]),
        .h  (mem[7]),
        .sel(address),
        .out(mux_out)
    );

`ifdef RAM8_BYPASS_EN
    // Forward only writes that will actually be accepted at the coming edge.
    assign out = (load && !busy && !clear && !reset) ? in : mux_out;
`else
    assign out = mux_out;
`endif

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: a word-level memory model checked every cycle plus directed literal checks.
module tb_ram8;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        load;
    logic [2:0]  address;
    logic        clear;
    logic [15:0] out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [8];
    int          model_busy_left = 0;
    bit          compare_on = 1'b0;

    int wdata [8] = '{246, 2, 3, 4, 5, 6, 7, 8};

    ram8 dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_data),
        .load   (load),
        .address(address),
        .clear  (clear),
        .out    (out),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic c,
                                 input logic [2:0] a, input logic [15:0] d);
        @(posedge clk);
        #2;
        reset   = r;
        load    = l;
        clear   = c;
        address = a;
        in_data = d;
    endtask

    // Model: a clear request arms an eight-edge countdown that zeroes word (8 - remaining) each edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) model_mem[i] = '0;
            model_busy_left = 0;
        end else if (model_busy_left > 0) begin
            model_mem[8 - model_busy_left] = 16'h0000;
            model_busy_left = model_busy_left - 1;
        end else if (clear) begin
            model_busy_left = 8;
        end else if (load) begin
            model_mem[address] = in_data;
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            logic [15:0] exp_out;
            exp_out = model_mem[address];
`ifdef RAM8_BYPASS_EN
            if (load && model_busy_left == 0 && !clear && !reset) exp_out = in_data;
`endif
            checkOutput("model_out", out, exp_out);
            checkOutput("model_busy", busy, (model_busy_left > 0) ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_cycles;

        reset   = 1'b1;
        load    = 1'b0;
        clear   = 1'b0;
        address = 3'd0;
        in_data = 16'd0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        compare_on = 1'b1;
        @(negedge clk);
        checkOutput("reset_out", out, 0);
        checkOutput("reset_busy", busy, 0);

        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 3'(i), 16'(wdata[i]));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 3'(i), 0);
            @(negedge clk);
            checkOutput($sformatf("sweep_%0d", i), out, wdata[i]);
        end

        applyStimulus(0, 1, 0, 3, 100);
        @(negedge clk);
`ifdef RAM8_BYPASS_EN
        checkOutput("write_cycle", out, 100);
`else
        checkOutput("write_cycle", out, 4);
`endif
        applyStimulus(0, 0, 0, 3, 0);
        @(negedge clk);
        checkOutput("after_write", out, 100);

        // Clear with full memory; address 7 must hold 8 until the eighth clearing edge.
        applyStimulus(0, 0, 1, 7, 0);
        busy_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(0, 0, 0, 7, 0);
            @(negedge clk);
            if (busy) busy_cycles++;
            if (k == 1) checkOutput("clr_first_out7", out, 8);
            if (k == 8) checkOutput("clr_last_out7", out, 8);
            if (k == 9) begin
                checkOutput("clr_done_out7", out, 0);
                checkOutput("clr_done_busy", busy, 0);
            end
        end
        checkOutput("busy_len", busy_cycles, 8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 3'(i), 0);
            @(negedge clk);
            checkOutput($sformatf("cleared_%0d", i), out, 0);
        end

        applyStimulus(0, 1, 0, 6, 11);
        applyStimulus(0, 0, 1, 0, 0);
        busy_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3)      applyStimulus(0, 1, 0, 2, 55);
            else if (k == 5) applyStimulus(0, 0, 1, 0, 0);
            else             applyStimulus(0, 0, 0, 0, 0);
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        checkOutput("busy_len_ignored", busy_cycles, 8);
        applyStimulus(0, 0, 0, 2, 0);
        @(negedge clk);
        checkOutput("dropped_load_2", out, 0);
        applyStimulus(0, 0, 0, 6, 0);
        @(negedge clk);
        checkOutput("cleared_6", out, 0);

        applyStimulus(0, 1, 0, 5, 77);
        applyStimulus(0, 1, 1, 5, 9);
        busy_cycles = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 0, 0, 5, 0);
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        checkOutput("busy_len_prio", busy_cycles, 8);
        checkOutput("clear_over_load_5", out, 0);

        // Refill, start a clear, then reset during busy cycle 4.
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 3'(i), 16'(wdata[i]));
        applyStimulus(0, 0, 1, 7, 0);
        for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 0, 7, 0);
        applyStimulus(1, 0, 0, 7, 0);
        @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        checkOutput("pre_reset_out7", out, 8);
        applyStimulus(0, 0, 0, 7, 0);
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out7", out, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 3'(i), 0);
            @(negedge clk);
            checkOutput($sformatf("abort_word_%0d", i), out, 0);
            checkOutput($sformatf("abort_idle_%0d", i), busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
